// File: rtl/nla_frame_sequencer.sv
// nla_frame_sequencer: strips NaN frame markers, sequences BRAM FIFO fill/drain and streams frames out with a last flag
//
// Optional feature macro: NLA_SEQ_STATS_EN (frames_o completed-frame counter; tied to 0 when undefined)
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset (drive the FIFO reset as ~rst_i)
//   s_valid_i/s_data_i/s_ready_o upstream sample stream (MARKER words delimit frames)
//   fifo_wr_en_o/fifo_wdata_o    FIFO write port, fires in the upstream accept cycle during FILL
//   fifo_rd_en_o/fifo_rdata_i    FIFO read port, data returns one cycle after the enable
//   fifo_full_i/fifo_empty_i     FIFO status
//   m_valid_o/m_data_o/m_last_o  downstream stream, m_ready_i accepts
//   frame_len_o                  length of the frame being drained
//   busy_o                       FSM not idle
//   overflow_o                   sticky truncation / protocol-error flag
//   frames_o                     saturating completed-frame count
module nla_frame_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_LINES = 12,
  parameter logic [DATA_W-1:0] MARKER = DATA_W'(32'h7F90_0000)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  input  logic [DATA_W-1:0]     s_data_i,
  output logic                  s_ready_o,
  output logic                  fifo_wr_en_o,
  output logic [DATA_W-1:0]     fifo_wdata_o,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_W-1:0]     fifo_rdata_i,
  input  logic                  fifo_full_i,
  input  logic                  fifo_empty_i,
  output logic                  m_valid_o,
  output logic [DATA_W-1:0]     m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic [ADDR_LINES:0]   frame_len_o,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic [15:0]           frames_o
);
  localparam int CW = ADDR_LINES + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_LINES{1'b0}}};
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, len_q, len_d, rd_q, rd_d, sent_q, sent_d;
  logic [1:0] bcnt_q, bcnt_d, slot;
  logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d;
  logic infl_q, ovf_q, ovf_d, skip_q, skip_d;
  logic is_mk, cnt_full, s_acc, pop, done, err, rd_en;
  assign is_mk = s_data_i == MARKER;
  assign cnt_full = cnt_q == DEPTH;
  // Gated by rst_i so the upstream sees not-ready for the whole reset pulse.
  assign s_ready_o = ~rst_i & ((state_q == IDLE) | ((state_q == FILL) & ~fifo_full_i & ~cnt_full));
  assign s_acc = s_valid_i & s_ready_o;
  assign fifo_wr_en_o = (state_q == FILL) & s_acc & ~is_mk;
  assign fifo_wdata_o = s_data_i;
  assign m_valid_o = bcnt_q != 2'd0;
  assign m_data_o = b0_q;
  assign m_last_o = m_valid_o & (sent_q + CW'(1) == len_q);
  assign pop = m_valid_o & m_ready_i;
  assign done = pop & m_last_o;
  assign err = (state_q == DRAIN) & fifo_empty_i & (rd_q < len_q);
  // Occupancy counts the word popped this cycle as gone, so m_ready_i=1 sustains one read per cycle.
  assign rd_en = (state_q == DRAIN) & (rd_q < len_q) & ~fifo_empty_i & (3'(bcnt_q) + 3'(infl_q) - 3'(pop) < 3'd2);
  assign fifo_rd_en_o = rd_en;
  assign frame_len_o = len_q;
  assign busy_o = state_q != IDLE;
  assign overflow_o = ovf_q;
  // Two-entry FIFO-ordered buffer: b0 is the head, a returning word lands in the first free slot after the pop.
  assign slot = bcnt_q - 2'(pop);
  always_comb begin
    b0_d = pop ? b1_q : b0_q;
    b1_d = b1_q;
    if (infl_q && slot == 2'd0) b0_d = fifo_rdata_i;
    if (infl_q && slot != 2'd0) b1_d = fifo_rdata_i;
    bcnt_d = err ? 2'd0 : slot + 2'(infl_q);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    skip_d = skip_q;
    rd_d = (state_q == DRAIN) ? rd_q + CW'(rd_en) : '0;
    sent_d = (state_q == DRAIN) ? sent_q + CW'(pop) : '0;
    if (state_q == IDLE) begin
      // After a truncated frame, its closing marker is swallowed instead of opening a new frame.
      if (s_acc && is_mk) begin
        skip_d = 1'b0;
        cnt_d = '0;
        state_d = skip_q ? IDLE : FILL;
      end
    end else if (state_q == FILL) begin
      if (fifo_full_i || cnt_full) begin
        ovf_d = 1'b1;
        skip_d = 1'b1;
        len_d = cnt_q;
        state_d = (cnt_q == '0) ? IDLE : DRAIN;
      end else if (s_acc && is_mk) begin
        len_d = cnt_q;
        state_d = (cnt_q == '0) ? IDLE : DRAIN;
      end else if (s_acc) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (state_q == DRAIN) begin
      ovf_d = ovf_q | err;
      state_d = (err || done) ? IDLE : DRAIN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      len_q <= '0;
      rd_q <= '0;
      sent_q <= '0;
      bcnt_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      infl_q <= 1'b0;
      ovf_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      rd_q <= rd_d;
      sent_q <= sent_d;
      bcnt_q <= bcnt_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      infl_q <= rd_en;
      ovf_q <= ovf_d;
      skip_q <= skip_d;
    end
  end
`ifdef NLA_SEQ_STATS_EN
  logic [15:0] frames_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) frames_q <= '0;
    else if (done && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
  end
  assign frames_o = frames_q;
`else
  assign frames_o = 16'd0;
`endif
endmodule

// File: tb/tb_nla_frame_sequencer.sv
// tb_nla_frame_sequencer: table-driven, directed and randomized checks of nla_frame_sequencer against a frame-level model
module tb_nla_frame_sequencer;
  localparam int AL = 5;
  localparam int DEPTH = 1 << AL;
  localparam logic [31:0] MK = 32'h7F90_0000;
  logic clk_i = 0, rst_i = 1, s_valid_i = 0, m_ready_i = 0;
  logic [31:0] s_data_i = 0;
  logic s_ready_o, fifo_wr_en_o, fifo_rd_en_o, fifo_full_i, fifo_empty_i;
  logic m_valid_o, m_last_o, busy_o, overflow_o;
  logic [31:0] fifo_wdata_o, fifo_rdata_i, m_data_o;
  logic [AL:0] frame_len_o;
  logic [15:0] frames_o;
  nla_frame_sequencer #(.DATA_W(32), .ADDR_LINES(AL), .MARKER(MK)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_wdata_o(fifo_wdata_o), .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_rdata_i(fifo_rdata_i), .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .frame_len_o(frame_len_o), .busy_o(busy_o), .overflow_o(overflow_o), .frames_o(frames_o)
  );
  always #5 clk_i = ~clk_i;
  logic [31:0] fq[$];
  logic [31:0] frd = 0;
  int fcount = 0;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fq.delete();
      fcount <= 0;
    end else if (fifo_wr_en_o) begin
      fq.push_back(fifo_wdata_o);
      fcount <= fcount + 1;
    end else if (fifo_rd_en_o && fq.size() > 0) begin
      frd <= fq.pop_front();
      fcount <= fcount - 1;
    end
  end
  assign fifo_rdata_i = frd;
  assign fifo_full_i = fcount == DEPTH;
  assign fifo_empty_i = fcount == 0;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  typedef struct packed {logic [31:0] d; logic l;} ow_t;
  ow_t expq[$];
  logic [31:0] mbuf[$];
  int mmode = 0, mframes = 0, hs_cnt = 0, outst = 0;
  bit movf = 0, pstall = 0, ewr, rand_rdy = 0;
  logic [31:0] pdata;
  logic plast;
  ow_t e;
  function automatic void model_reset();
    mmode = 0;
    mbuf.delete();
    expq.delete();
    movf = 0;
    mframes = 0;
  endfunction
  function automatic void emit();
    foreach (mbuf[i]) expq.push_back('{d: mbuf[i], l: (i == mbuf.size() - 1)});
    mbuf.delete();
  endfunction
  // mode 0: outside a frame, 1: collecting a frame, 2: discarding the tail of a truncated frame
  function automatic bit model_feed(input logic [31:0] w);
    bit wr = 0;
    if (mmode == 0) begin
      if (w == MK) begin mmode = 1; mbuf.delete(); end
    end else if (mmode == 2) begin
      if (w == MK) mmode = 0;
    end else if (w == MK) begin
      emit();
      mmode = 0;
    end else begin
      wr = 1;
      mbuf.push_back(w);
      if (mbuf.size() == DEPTH) begin emit(); movf = 1; mmode = 2; end
    end
    return wr;
  endfunction
  function automatic logic [15:0] ef(input int n);
`ifdef NLA_SEQ_STATS_EN
    return 16'(n);
`else
    return 16'(n & 0);
`endif
  endfunction
  initial forever begin
    @(negedge clk_i);
    #3;
    if (rst_i) begin
      outst = 0;
      pstall = 0;
    end else begin
      chk("wr_rd_exclusive", 32'(fifo_wr_en_o & fifo_rd_en_o), 0);
      if (m_valid_o || fifo_rd_en_o) chk("s_ready_in_drain", 32'(s_ready_o), 0);
      ewr = (s_valid_i && s_ready_o) ? model_feed(s_data_i) : 1'b0;
      chk("fifo_wr_en", 32'(fifo_wr_en_o), 32'(ewr));
      if (ewr) chk("fifo_wdata", fifo_wdata_o, s_data_i);
      if (pstall) begin
        chk("hold_valid", 32'(m_valid_o), 1);
        chk("hold_data", m_data_o, pdata);
        chk("hold_last", 32'(m_last_o), 32'(plast));
      end
      outst += int'(fifo_rd_en_o) - int'(m_valid_o & m_ready_i);
      chk("outstanding_le_2", 32'(outst <= 2), 1);
      if (m_valid_o && m_ready_i) begin
        hs_cnt++;
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h expected none", m_data_o);
        end else begin
          e = expq.pop_front();
          chk("m_data", m_data_o, e.d);
          chk("m_last", 32'(m_last_o), 32'(e.l));
          if (e.l) mframes++;
        end
      end
      pstall = m_valid_o & ~m_ready_i;
      pdata = m_data_o;
      plast = m_last_o;
    end
  end
  initial forever begin
    @(negedge clk_i);
    if (rand_rdy) m_ready_i = $urandom_range(0, 3) != 0;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  function automatic logic [31:0] rw();
    logic [31:0] w = $urandom;
    return (w == MK) ? w ^ 32'h1 : w;
  endfunction
  task automatic send(input logic [31:0] w, input int gap);
    bit ok;
    int g = 0;
    repeat (gap) begin s_valid_i = 0; @(negedge clk_i); end
    s_valid_i = 1;
    s_data_i = w;
    do begin
      #1;
      ok = s_ready_o;
      @(negedge clk_i);
      g++;
    end while (!ok && g < 3000);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no accept expected accept of %h", w);
    end
    s_valid_i = 0;
  endtask
  task automatic send_frame(input int n, input int gmax);
    send(MK, $urandom_range(0, gmax));
    for (int i = 0; i < n; i++) send(rw(), $urandom_range(0, gmax));
    send(MK, $urandom_range(0, gmax));
  endtask
  task automatic wait_idle(input string nm);
    int g = 0;
    while ((busy_o || expq.size() != 0) && g < 3000) begin @(negedge clk_i); g++; end
    chk({nm, "_busy"}, 32'(busy_o), 0);
    chk({nm, "_pending"}, 32'(expq.size()), 0);
  endtask
  task automatic wait_hs(input int target);
    int g = 0;
    while (hs_cnt < target && g < 500) begin @(negedge clk_i); g++; end
    chk("wait_handshakes", 32'(hs_cnt >= target), 1);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_s_ready"}, 32'(s_ready_o), 0);
    chk({nm, "_wr_en"}, 32'(fifo_wr_en_o), 0);
    chk({nm, "_rd_en"}, 32'(fifo_rd_en_o), 0);
    chk({nm, "_m_valid"}, 32'(m_valid_o), 0);
    chk({nm, "_m_last"}, 32'(m_last_o), 0);
    chk({nm, "_busy"}, 32'(busy_o), 0);
    chk({nm, "_overflow"}, 32'(overflow_o), 0);
    chk({nm, "_frame_len"}, 32'(frame_len_o), 0);
    chk({nm, "_frames"}, 32'(frames_o), 0);
  endtask
  typedef struct {
    logic sv; logic [31:0] sd; logic mr;
    logic sr, wr, rd, mv; logic [31:0] md; logic ml, bz;
  } vec_t;
  vec_t tbl[11];
  initial begin
    tbl[0]  = '{1, MK,           1, 1, 0, 0, 0, 0,            0, 0};
    tbl[1]  = '{1, 32'h3F800000, 1, 1, 1, 0, 0, 0,            0, 1};
    tbl[2]  = '{1, 32'h40000000, 1, 1, 1, 0, 0, 0,            0, 1};
    tbl[3]  = '{1, 32'h40400000, 1, 1, 1, 0, 0, 0,            0, 1};
    tbl[4]  = '{1, MK,           1, 1, 0, 0, 0, 0,            0, 1};
    tbl[5]  = '{0, 0,            1, 0, 0, 1, 0, 0,            0, 1};
    tbl[6]  = '{0, 0,            1, 0, 0, 1, 0, 0,            0, 1};
    tbl[7]  = '{0, 0,            1, 0, 0, 1, 1, 32'h3F800000, 0, 1};
    tbl[8]  = '{0, 0,            1, 0, 0, 0, 1, 32'h40000000, 0, 1};
    tbl[9]  = '{0, 0,            1, 0, 0, 0, 1, 32'h40400000, 1, 1};
    tbl[10] = '{0, 0,            1, 1, 0, 0, 0, 0,            0, 0};
    repeat (2) @(negedge clk_i);
    #1;
    chk_reset("reset");
    @(negedge clk_i);
    rst_i = 0;
    #1;
    chk("release_s_ready", 32'(s_ready_o), 1);
    for (int i = 0; i < 11; i++) begin
      s_valid_i = tbl[i].sv;
      s_data_i = tbl[i].sd;
      m_ready_i = tbl[i].mr;
      #1;
      chk($sformatf("row%0d_s_ready", i), 32'(s_ready_o), 32'(tbl[i].sr));
      chk($sformatf("row%0d_wr_en", i), 32'(fifo_wr_en_o), 32'(tbl[i].wr));
      chk($sformatf("row%0d_rd_en", i), 32'(fifo_rd_en_o), 32'(tbl[i].rd));
      chk($sformatf("row%0d_m_valid", i), 32'(m_valid_o), 32'(tbl[i].mv));
      chk($sformatf("row%0d_m_last", i), 32'(m_last_o), 32'(tbl[i].ml));
      chk($sformatf("row%0d_busy", i), 32'(busy_o), 32'(tbl[i].bz));
      if (tbl[i].mv) chk($sformatf("row%0d_m_data", i), m_data_o, tbl[i].md);
      @(negedge clk_i);
    end
    chk("normal_frame_len", 32'(frame_len_o), 3);
    chk("normal_frames", 32'(frames_o), 32'(ef(1)));
    chk("normal_overflow", 32'(overflow_o), 0);
    send(MK, 0);
    chk("empty_busy_in_fill", 32'(busy_o), 1);
    send(MK, 0);
    chk("empty_back_idle", 32'(busy_o), 0);
    chk("empty_overflow", 32'(overflow_o), 0);
    chk("empty_frames", 32'(frames_o), 32'(ef(1)));
    send_frame(6, 0);
    wait_hs(hs_cnt + 2);
    m_ready_i = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stall_valid", 32'(m_valid_o), 1);
      @(negedge clk_i);
    end
    m_ready_i = 1;
    wait_idle("backpressure");
    chk("backpressure_len", 32'(frame_len_o), 6);
    chk("backpressure_frames", 32'(frames_o), 32'(ef(2)));
    rand_rdy = 1;
    send(MK, 0);
    for (int i = 0; i < DEPTH + 3; i++) send(rw(), 0);
    send(MK, 0);
    wait_idle("overflow");
    chk("overflow_flag", 32'(overflow_o), 1);
    chk("overflow_len", 32'(frame_len_o), DEPTH);
    chk("overflow_frames", 32'(frames_o), 32'(ef(3)));
    send_frame(3, 1);
    wait_idle("after_overflow");
    chk("after_overflow_len", 32'(frame_len_o), 3);
    chk("after_overflow_frames", 32'(frames_o), 32'(ef(4)));
    rand_rdy = 0;
    m_ready_i = 1;
    send_frame(5, 0);
    wait_hs(hs_cnt + 2);
    rst_i = 1;
    model_reset();
    #1;
    chk_reset("mid_drain_reset");
    @(negedge clk_i);
    rst_i = 0;
    send_frame(2, 0);
    wait_idle("post_reset");
    chk("post_reset_len", 32'(frame_len_o), 2);
    chk("post_reset_frames", 32'(frames_o), 32'(ef(1)));
    rand_rdy = 1;
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) send(rw(), $urandom_range(0, 2));
      send_frame($urandom_range(0, DEPTH + 4), 2);
    end
    wait_idle("random");
    chk("random_overflow", 32'(overflow_o), 32'(movf));
    chk("random_frames", 32'(frames_o), 32'(ef(mframes)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
